// File: rtl/mesi_pkg.sv
// rtl/mesi_pkg.sv - shared types for the MESI bus side: message codes, line states, bus FSM states
package mesi_pkg;

  typedef enum logic [1:0] {
    MSG_NONE       = 2'b00,
    MSG_READ_MISS  = 2'b01,
    MSG_WRITE_MISS = 2'b10,
    MSG_INVALIDATE = 2'b11
  } msg_e;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_state_e;

  typedef enum logic [2:0] {
    BUS_IDLE  = 3'd0,
    BUS_BCAST = 3'd1,
    BUS_SNOOP = 3'd2,
    BUS_WB    = 3'd3,
    BUS_MEM   = 3'd4,
    BUS_DONE  = 3'd5
  } bus_state_e;

endpackage

// File: rtl/decodificadorComportamental.sv
// rtl/decodificadorComportamental.sv - active-low 7-seg decoder, code 4'hF blanks (only with MESI_HEX_DEBUG_EN)
`ifdef MESI_HEX_DEBUG_EN
module decodificadorComportamental (
  input  logic [3:0] c,
  output logic [0:6] h
);

  always_comb begin
    case (c)
      4'd0:    h = 7'b0000001;
      4'd1:    h = 7'b1001111;
      4'd2:    h = 7'b0010010;
      4'd3:    h = 7'b0000110;
      4'd4:    h = 7'b1001100;
      4'd5:    h = 7'b0100100;
      default: h = 7'b1111111;
    endcase
  end

endmodule
`endif

// File: rtl/mesi_rr_arbiter.sv
// rtl/mesi_rr_arbiter.sv - combinational round-robin pick: first eligible index after the pointer
module mesi_rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    // Scan ptr+1 .. ptr+N so the previous winner gets lowest priority.
    for (int off = 1; off <= N; off++) begin
      j = IW'((int'(ptr) + off) % N);
      if (!valid && elig[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/mesi_barramento.sv
// rtl/mesi_barramento.sv - MESI shared bus: round-robin grant, broadcast, snoop collect, memory/write-back; MESI_HEX_DEBUG_EN adds HEX0/HEX1
module mesi_barramento
  import mesi_pkg::*;
#(
  parameter int N_CACHES = 3,
  parameter int ADDR_W   = 4,
  parameter int MEM_LAT  = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_CACHES-1:0]        req,
  input  logic [2*N_CACHES-1:0]      req_msg,
  input  logic [ADDR_W*N_CACHES-1:0] req_addr,
  output logic [N_CACHES-1:0]        gnt,
  output logic                       bcast_valid,
  output logic [1:0]                 bcast_msg,
  output logic [ADDR_W-1:0]          bcast_addr,
  output logic [N_CACHES-1:0]        bcast_src,
  input  logic [N_CACHES-1:0]        snp_shared,
  input  logic [N_CACHES-1:0]        snp_wb,
  output logic                       mem_rd,
  output logic                       mem_abort,
  output logic                       shared_out,
  output logic [N_CACHES-1:0]        done,
  output logic                       busy
`ifdef MESI_HEX_DEBUG_EN
  ,
  output logic [0:6]                 HEX0,
  output logic [0:6]                 HEX1
`endif
);

  localparam int IW = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;
  localparam int CW = $clog2(MEM_LAT + 1);

  bus_state_e          state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [N_CACHES-1:0] gnt_q, gnt_d;
  msg_e                msg_q, msg_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                flag_q, flag_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [N_CACHES-1:0] elig, arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_valid;
  logic [1:0]          win_msg;
  logic [ADDR_W-1:0]   win_addr;
  logic                snp_sh_any, snp_wb_any;

  always_comb begin
    elig     = '0;
    win_msg  = '0;
    win_addr = '0;
    for (int i = 0; i < N_CACHES; i++) begin
      elig[i] = req[i] && (req_msg[2*i +: 2] != MSG_NONE);
      if (arb_gnt[i]) begin
        win_msg  = req_msg[2*i +: 2];
        win_addr = req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  mesi_rr_arbiter #(.N(N_CACHES), .IW(IW)) u_arb (
    .elig  (elig),
    .ptr   (rr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // The owner's own snoop bits never count toward sharing or write-back.
  assign snp_sh_any = |(snp_shared & ~gnt_q);
  assign snp_wb_any = |(snp_wb & ~gnt_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BUS_IDLE;
      rr_q    <= IW'(N_CACHES - 1);
      gnt_q   <= '0;
      msg_q   <= MSG_NONE;
      addr_q  <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      msg_q   <= msg_d;
      addr_q  <= addr_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    msg_d   = msg_q;
    addr_d  = addr_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    case (state_q)
      BUS_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_gnt;
          msg_d   = msg_e'(win_msg);
          addr_d  = win_addr;
          rr_d    = arb_idx;
          state_d = BUS_BCAST;
        end
      end
      BUS_BCAST: state_d = BUS_SNOOP;
      BUS_SNOOP: begin
        flag_d = (msg_q != MSG_INVALIDATE) && (snp_sh_any || snp_wb_any);
        cnt_d  = '0;
        if (msg_q == MSG_INVALIDATE) state_d = BUS_DONE;
        else if (snp_wb_any)         state_d = BUS_WB;
        else                         state_d = BUS_MEM;
      end
      BUS_WB: state_d = BUS_DONE;
      BUS_MEM: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MEM_LAT - 1)) state_d = BUS_DONE;
      end
      BUS_DONE: begin
        gnt_d   = '0;
        state_d = BUS_IDLE;
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != BUS_IDLE);
    gnt         = gnt_q;
    bcast_valid = (state_q == BUS_BCAST);
    bcast_msg   = busy ? msg_q : 2'b00;
    bcast_addr  = busy ? addr_q : '0;
    bcast_src   = gnt_q;
    mem_rd      = (state_q == BUS_MEM);
    mem_abort   = (state_q == BUS_WB);
    shared_out  = (state_q == BUS_DONE) && flag_q;
    done        = (state_q == BUS_DONE) ? gnt_q : '0;
  end

`ifdef MESI_HEX_DEBUG_EN
  decodificadorComportamental u_hex0 (
    .c ({1'b0, state_q}),
    .h (HEX0)
  );
  decodificadorComportamental u_hex1 (
    .c (busy ? {2'b00, msg_q} : 4'hF),
    .h (HEX1)
  );
`endif

endmodule

// File: tb/tb_mesi_barramento.sv
// tb/tb_mesi_barramento.sv - directed self-checking bench for mesi_barramento
module tb_mesi_barramento;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [5:0]  req_msg;
  logic [11:0] req_addr;
  logic [2:0]  gnt;
  logic        bcast_valid;
  logic [1:0]  bcast_msg;
  logic [3:0]  bcast_addr;
  logic [2:0]  bcast_src;
  logic [2:0]  snp_shared;
  logic [2:0]  snp_wb;
  logic        mem_rd;
  logic        mem_abort;
  logic        shared_out;
  logic [2:0]  done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  int         w_bc, w_done, w_rd, w_ab, w_abt;
  logic [2:0] w_donev, w_src;
  logic [1:0] w_msg;
  logic [3:0] w_addr;
  logic       w_sh, w_multi;

  mesi_barramento #(.N_CACHES(3), .ADDR_W(4), .MEM_LAT(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_msg    (req_msg),
    .req_addr   (req_addr),
    .gnt        (gnt),
    .bcast_valid(bcast_valid),
    .bcast_msg  (bcast_msg),
    .bcast_addr (bcast_addr),
    .bcast_src  (bcast_src),
    .snp_shared (snp_shared),
    .snp_wb     (snp_wb),
    .mem_rd     (mem_rd),
    .mem_abort  (mem_abort),
    .shared_out (shared_out),
    .done       (done),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Steps from the IDLE cycle in which req is seen (cycle 0) until done or max cycles.
  task automatic watch(input int max, input int drop_at);
    w_bc = -1; w_done = -1; w_rd = 0; w_ab = 0; w_abt = -1;
    w_donev = '0; w_src = '0; w_msg = '0; w_addr = '0; w_sh = 1'b0; w_multi = 1'b0;
    for (int k = 1; k <= max; k++) begin
      step();
      if ($countones(gnt) > 1) w_multi = 1'b1;
      if (bcast_valid && w_bc < 0) begin
        w_bc = k; w_msg = bcast_msg; w_addr = bcast_addr; w_src = bcast_src;
      end
      if (mem_rd) w_rd++;
      if (mem_abort) begin
        w_ab++;
        if (w_abt < 0) w_abt = k;
      end
      if (k == drop_at) begin
        req = '0; req_msg = '1; req_addr = '1;
      end
      if (done != 0) begin
        w_done = k; w_donev = done; w_sh = shared_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; req_msg = '0; req_addr = '0; snp_shared = '0; snp_wb = '0;
    repeat (3) step();
    total++;
    if ({gnt, bcast_valid, bcast_msg, bcast_addr, bcast_src, mem_rd, mem_abort, shared_out, done, busy} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs got %h want 0", {gnt, bcast_valid, bcast_msg, bcast_addr, bcast_src, mem_rd, mem_abort, shared_out, done, busy});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_read_miss();
    req_msg = 6'b00_00_01; req_addr = 12'h005; snp_shared = '0; snp_wb = '0; req = 3'b001;
    watch(12, 1);
    total++; if (w_bc !== 1) begin bad++; $display("FAIL rm_bcast_cycle got %0d want 1", w_bc); end
    total++; if (w_msg !== 2'b01) begin bad++; $display("FAIL rm_bcast_msg got %b want 01", w_msg); end
    total++; if (w_addr !== 4'h5) begin bad++; $display("FAIL rm_bcast_addr got %h want 5", w_addr); end
    total++; if (w_src !== 3'b001) begin bad++; $display("FAIL rm_bcast_src got %b want 001", w_src); end
    total++; if (w_rd !== 2) begin bad++; $display("FAIL rm_mem_rd_cycles got %0d want 2", w_rd); end
    total++; if (w_ab !== 0) begin bad++; $display("FAIL rm_abort got %0d want 0", w_ab); end
    total++; if (w_done !== 5) begin bad++; $display("FAIL rm_done_cycle got %0d want 5", w_done); end
    total++; if (w_donev !== 3'b001) begin bad++; $display("FAIL rm_done_vec got %b want 001", w_donev); end
    total++; if (w_sh !== 1'b0) begin bad++; $display("FAIL rm_shared got %b want 0", w_sh); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_idle_after got %b want 0", busy); end
  endtask

  task automatic test_write_back();
    req_msg = 6'b00_10_00; req_addr = 12'h090; snp_shared = '0; snp_wb = 3'b100; req = 3'b010;
    watch(12, 0);
    total++; if (w_msg !== 2'b10) begin bad++; $display("FAIL wb_bcast_msg got %b want 10", w_msg); end
    total++; if (w_addr !== 4'h9) begin bad++; $display("FAIL wb_bcast_addr got %h want 9", w_addr); end
    total++; if (w_abt !== 3) begin bad++; $display("FAIL wb_abort_cycle got %0d want 3", w_abt); end
    total++; if (w_ab !== 1) begin bad++; $display("FAIL wb_abort_count got %0d want 1", w_ab); end
    total++; if (w_rd !== 0) begin bad++; $display("FAIL wb_mem_rd got %0d want 0", w_rd); end
    total++; if (w_done !== 4) begin bad++; $display("FAIL wb_done_cycle got %0d want 4", w_done); end
    total++; if (w_donev !== 3'b010) begin bad++; $display("FAIL wb_done_vec got %b want 010", w_donev); end
    total++; if (w_sh !== 1'b1) begin bad++; $display("FAIL wb_shared got %b want 1", w_sh); end
    req = '0; snp_wb = '0;
    step();
  endtask

  task automatic test_invalidate();
    req_msg = 6'b11_00_00; req_addr = 12'h300; snp_shared = 3'b011; snp_wb = '0; req = 3'b100;
    watch(12, 0);
    total++; if (w_done !== 3) begin bad++; $display("FAIL inv_done_cycle got %0d want 3", w_done); end
    total++; if (w_donev !== 3'b100) begin bad++; $display("FAIL inv_done_vec got %b want 100", w_donev); end
    total++; if (w_rd !== 0 || w_ab !== 0) begin bad++; $display("FAIL inv_mem got rd=%0d ab=%0d want 0 0", w_rd, w_ab); end
    total++; if (w_sh !== 1'b0) begin bad++; $display("FAIL inv_shared got %b want 0", w_sh); end
    req = '0; snp_shared = '0;
    step();
    req_msg = 6'b01_00_00; req_addr = 12'h700; snp_shared = 3'b100; req = 3'b100;
    watch(12, 0);
    total++; if (w_done !== 5) begin bad++; $display("FAIL own_done_cycle got %0d want 5", w_done); end
    total++; if (w_sh !== 1'b0) begin bad++; $display("FAIL own_shared got %b want 0", w_sh); end
    req = '0; snp_shared = '0;
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_order [4];
    exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100; exp_order[3] = 3'b001;
    req_msg = 6'b01_01_01; req_addr = 12'h321; snp_shared = '0; snp_wb = '0; req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      watch(12, 0);
      total++; if (w_donev !== exp_order[n]) begin bad++; $display("FAIL rr_order%0d got %b want %b", n, w_donev, exp_order[n]); end
      total++; if (w_bc !== 1) begin bad++; $display("FAIL rr_bcast%0d got %0d want 1", n, w_bc); end
      total++; if (w_multi !== 1'b0) begin bad++; $display("FAIL rr_onehot%0d got %b want 0", n, w_multi); end
      if (n == 3) req = '0;
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_gap%0d got %b want 0", n, busy); end
    end
  endtask

  task automatic test_reset_mid();
    req_msg = 6'b00_01_00; req_addr = 12'h0A0; snp_shared = '0; snp_wb = '0; req = 3'b010;
    repeat (3) step();
    total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL rst_in_mem got %b want 1", mem_rd); end
    reset = 1'b1; req = '0;
    step();
    total++;
    if ({gnt, bcast_valid, bcast_msg, bcast_addr, bcast_src, mem_rd, mem_abort, shared_out, done, busy} !== 20'h0) begin
      bad++;
      $display("FAIL rst_mid_outputs got %h want 0", {gnt, bcast_valid, bcast_msg, bcast_addr, bcast_src, mem_rd, mem_abort, shared_out, done, busy});
    end
    reset = 1'b0;
    step();
    total++; if (done !== 3'b000 || busy !== 1'b0) begin bad++; $display("FAIL rst_no_done got done=%b busy=%b want 000 0", done, busy); end
    req_msg = 6'b01_00_01; req_addr = 12'h000; req = 3'b101;
    watch(12, 0);
    total++; if (w_donev !== 3'b001) begin bad++; $display("FAIL rst_ptr_first got %b want 001", w_donev); end
    req = 3'b100;
    step();
    watch(12, 0);
    total++; if (w_donev !== 3'b100) begin bad++; $display("FAIL rst_ptr_second got %b want 100", w_donev); end
    req = '0;
    step();
  endtask

  task automatic test_none_msg();
    logic seen;
    seen = 1'b0;
    req_msg = 6'b00_00_00; req_addr = 12'hFFF; req = 3'b111;
    repeat (6) begin
      step();
      if (busy !== 1'b0 || gnt !== 3'b000) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL none_granted got %b want 0", seen); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_back();
    test_invalidate();
    test_round_robin();
    test_reset_mid();
    test_none_msg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesi_barramento.md
Name: mesi_barramento

Overview:
- Shared-bus side of the MESI protocol: the counterpart that consumes the bus messages emitted by per-cache emitters and drives the snoop receivers.
- Arbitrates among N_CACHES requesters round-robin and broadcasts the granted message/address to all caches.
- Collects snoop responses (shared, write-back) and either lets memory serve the line or aborts the memory access when an M-owner supplies it.
- Sits between cache controllers and the memory model; one transaction in flight at a time.

Parameters:
N_CACHES, 3, number of cache ports (2..8)
ADDR_W, 4, line address width
MEM_LAT, 2, memory read latency in cycles (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
req  in  N_CACHES  request per cache; held until matching done
req_msg  in  2*N_CACHES  message per cache, cache i at [2i+1:2i]
req_addr  in  ADDR_W*N_CACHES  address per cache, cache i at [ADDR_W*i +: ADDR_W]
gnt  out  N_CACHES  one-hot owner, held for whole transaction
bcast_valid  out  1  one-cycle broadcast strobe
bcast_msg  out  2  broadcast message
bcast_addr  out  ADDR_W  broadcast address
bcast_src  out  N_CACHES  one-hot originator (snoopers ignore own message)
snp_shared  in  N_CACHES  snooper holds a valid copy
snp_wb  in  N_CACHES  snooper held line in M and is writing back
mem_rd  out  1  high during memory read cycles
mem_abort  out  1  one-cycle pulse: memory access cancelled, owner supplies data
shared_out  out  1  valid with done: some other cache holds the line
done  out  N_CACHES  one-cycle completion pulse to the owner
busy  out  1  state != IDLE

Behaviour:
- Message codes (package): 00 NONE, 01 READ_MISS, 10 WRITE_MISS, 11 INVALIDATE. A req with msg NONE is never granted.
- Reset: state IDLE, rr pointer = N_CACHES-1 (cache 0 has first priority), all outputs 0.
- FSM: IDLE, BCAST, SNOOP, WB, MEM, DONE.
- IDLE: if any eligible req, pick first eligible index after the rr pointer (wrapping N_CACHES-1 -> 0). Register gnt, msg and addr; update pointer to the winner; go to BCAST. No eligible req -> stay in IDLE.
- BCAST (1 cycle): bcast_valid=1; bcast_msg/bcast_addr/bcast_src are driven from the latched copy and stay stable until DONE.
- SNOOP (1 cycle): sample snp_shared and snp_wb masked by ~gnt; owner's bits are ignored. Register shared flag = OR of masked snp_shared | snp_wb.
  - INVALIDATE -> DONE.
  - Any masked snp_wb -> WB.
  - Otherwise -> MEM.
- WB (1 cycle): mem_abort=1, then DONE. Multiple snp_wb bits are treated as one write-back.
- MEM: mem_rd=1 for exactly MEM_LAT cycles (internal counter, width clog2(MEM_LAT+1)), then DONE.
- DONE (1 cycle): done[owner]=1, shared_out=flag (0 for INVALIDATE); clear gnt; go to IDLE. A new grant is possible in the following IDLE cycle.
- Latency, with req seen in IDLE cycle t:
  - bcast_valid at t+1.
  - done at t+3 for INVALIDATE, t+4 for write-back, t+3+MEM_LAT for a memory read.
- Owner drops req mid-transaction: the transaction still completes and done still pulses. Inputs req_msg/req_addr are not re-read after the grant.
- Reset mid-transaction: state returns to IDLE on the next edge, outputs are 0, the pointer is reset, and no done is issued.

Optional Feature:
MESI_HEX_DEBUG_EN
- Defined: adds outputs HEX0 [0:6] (FSM state code 0..5) and HEX1 [0:6] (bcast_msg, blank when IDLE), active-low 7-seg, driven through decodificadorComportamental.
- Undefined: these ports and decoders do not exist; core behaviour is identical.

Decomposition:
- Package mesi_pkg: message enum (NONE/READ_MISS/WRITE_MISS/INVALIDATE), MESI state enum (I=00,S=01,E=10,M=11), bus FSM state enum.
- Sub-module mesi_rr_arbiter: eligible mask + pointer -> one-hot grant and index, combinational. Rest in top.

Test Plan:
- Reset then req=001 READ_MISS addr 5, no snoop response -> bcast_valid at t+1 (msg 01, addr 5, src 001), mem_rd for 2 cycles, done=001 at t+5, shared_out=0.
- Cache1 WRITE_MISS with snp_wb=100 -> mem_abort pulse at t+3, mem_rd never high, done=010 at t+4.
- Cache2 INVALIDATE with snp_shared=011 -> no mem_rd/mem_abort, done=100 at t+3, shared_out=0. Owner snp_shared=100 alone -> shared_out=0 on a READ_MISS.
- All three req continuously asserted -> grant order 0,1,2,0 (wrap), one transaction at a time, busy low one cycle between transactions.
- Assert reset during MEM -> next cycle IDLE, all outputs 0, no done. Next req from cache 2 is granted after cache 0 priority check.
- req_msg=00 with req=1 -> never granted, busy stays 0.
